// File: rtl/gpio_bank.sv
// ============================================================================
//  Module   : gpio_bank
//  Purpose  : Parametrised GPIO bank. Direct and masked output / output-enable
//             writes, synchronised and debounced pad inputs, and sticky
//             edge/level interrupts behind a single-clock register port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_bank #(
   parameter int NumGpio        = 32,
   parameter int SyncStages     = 2,
   parameter int FilterCntWidth = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               reg_we_i,
   input  logic               reg_re_i,
   input  logic [3:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               reg_rvalid_o,
   input  logic [NumGpio-1:0] cio_gpio_i,
   output logic [NumGpio-1:0] cio_gpio_o,
   output logic [NumGpio-1:0] cio_gpio_en_o,
   output logic [NumGpio-1:0] intr_o
);

   localparam logic [3:0] ADDR_INTR_STATE   = 4'd0;
   localparam logic [3:0] ADDR_INTR_ENABLE  = 4'd1;
   localparam logic [3:0] ADDR_INTR_TEST    = 4'd2;
   localparam logic [3:0] ADDR_DATA_IN      = 4'd3;
   localparam logic [3:0] ADDR_DIRECT_OUT   = 4'd4;
   localparam logic [3:0] ADDR_MOUT_LOWER   = 4'd5;
   localparam logic [3:0] ADDR_MOUT_UPPER   = 4'd6;
   localparam logic [3:0] ADDR_DIRECT_OE    = 4'd7;
   localparam logic [3:0] ADDR_MOE_LOWER    = 4'd8;
   localparam logic [3:0] ADDR_MOE_UPPER    = 4'd9;
   localparam logic [3:0] ADDR_CTRL_RISE    = 4'd10;
   localparam logic [3:0] ADDR_CTRL_FALL    = 4'd11;
   localparam logic [3:0] ADDR_CTRL_LVLHI   = 4'd12;
   localparam logic [3:0] ADDR_CTRL_LVLLO   = 4'd13;
   localparam logic [3:0] ADDR_FILTER_EN    = 4'd14;
   localparam logic [3:0] ADDR_FILTER_THR   = 4'd15;

   localparam logic [FilterCntWidth-1:0] CNT_MAX = '1;

   // Architectural registers
   logic [NumGpio-1:0] intr_state_q, intr_state_d;
   logic [NumGpio-1:0] intr_enable_q, intr_enable_d;
   logic [NumGpio-1:0] out_q, out_d;
   logic [NumGpio-1:0] oe_q, oe_d;
   logic [NumGpio-1:0] rise_q, rise_d;
   logic [NumGpio-1:0] fall_q, fall_d;
   logic [NumGpio-1:0] lvlhi_q, lvlhi_d;
   logic [NumGpio-1:0] lvllo_q, lvllo_d;
   logic [NumGpio-1:0] filt_en_q, filt_en_d;
   logic [FilterCntWidth-1:0] thresh_q, thresh_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rvalid_q;

   // Input path and event wires
   logic [NumGpio-1:0] w_synced;
   logic [NumGpio-1:0] w_stable;
   logic [NumGpio-1:0] w_event;
   logic [NumGpio-1:0] w_w1c;
   logic [NumGpio-1:0] w_test;
   logic [31:0]        w_out32;
   logic [31:0]        w_oe32;

   // Masked write: mask in wdata[31:16], data in wdata[15:0]; the lower
   // register reaches pins 15:0, the upper one pins 31:16. Pins that do not
   // exist are simply never visited by the loop.
   function automatic logic [NumGpio-1:0] masked_update(
      input logic [NumGpio-1:0] cur,
      input logic [31:0]        wd,
      input logic               upper
   );
      logic [NumGpio-1:0] res;
      res = cur;
      for (int i = 0; i < NumGpio; i++) begin
         if (((i >= 16) == upper) && wd[16 + (i % 16)]) begin
            res[i] = wd[i % 16];
         end
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // Input synchroniser (bypassed when inputs are already synchronous)
   // -------------------------------------------------------------------------
   if (SyncStages > 0) begin : g_sync
      logic [NumGpio-1:0] sync_q [SyncStages];

      // Shift pad inputs through the synchroniser chain
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
         end else begin
            sync_q[0] <= cio_gpio_i;
            for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
         end
      end

      assign w_synced = sync_q[SyncStages-1];
   end else begin : g_nosync
      assign w_synced = cio_gpio_i;
   end

   // -------------------------------------------------------------------------
   // Per-pin debounce filter and edge/level event detection
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < NumGpio; gi++) begin : g_pin
      logic                      stable_q, stable_d;
      logic                      prev_q;
      logic [FilterCntWidth-1:0] cnt_q, cnt_d;

      // A change is accepted once it has been seen on THRESH+1 consecutive
      // cycles; with the filter off the stable value simply tracks the input.
      always_comb begin
         stable_d = stable_q;
         cnt_d    = cnt_q;
         if (!filt_en_q[gi]) begin
            stable_d = w_synced[gi];
            cnt_d    = '0;
         end else if (w_synced[gi] == stable_q) begin
            cnt_d    = '0;
         end else if (cnt_q == thresh_q) begin
            stable_d = w_synced[gi];
            cnt_d    = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d    = cnt_q + 1'b1;
         end
      end

      // Filter state and one-cycle history of the stable value
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
         end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
         end
      end

      assign w_stable[gi] = stable_q;
      assign w_event[gi]  = (~prev_q &  stable_q & rise_q[gi])
                          | ( prev_q & ~stable_q & fall_q[gi])
                          | ( stable_q & lvlhi_q[gi])
                          | (~stable_q & lvllo_q[gi]);
   end

   assign w_out32 = 32'(out_q);
   assign w_oe32  = 32'(oe_q);

   // -------------------------------------------------------------------------
   // Register write decode
   // -------------------------------------------------------------------------
   // Compute next values of all software-writable registers
   always_comb begin
      intr_enable_d = intr_enable_q;
      out_d         = out_q;
      oe_d          = oe_q;
      rise_d        = rise_q;
      fall_d        = fall_q;
      lvlhi_d       = lvlhi_q;
      lvllo_d       = lvllo_q;
      filt_en_d     = filt_en_q;
      thresh_d      = thresh_q;
      w_w1c         = '0;
      w_test        = '0;
      if (reg_we_i) begin
         case (reg_addr_i)
            ADDR_INTR_STATE:  w_w1c         = reg_wdata_i[NumGpio-1:0];
            ADDR_INTR_ENABLE: intr_enable_d = reg_wdata_i[NumGpio-1:0];
            ADDR_INTR_TEST:   w_test        = reg_wdata_i[NumGpio-1:0];
            ADDR_DIRECT_OUT:  out_d         = reg_wdata_i[NumGpio-1:0];
            ADDR_MOUT_LOWER:  out_d         = masked_update(out_q, reg_wdata_i, 1'b0);
            ADDR_MOUT_UPPER:  out_d         = masked_update(out_q, reg_wdata_i, 1'b1);
            ADDR_DIRECT_OE:   oe_d          = reg_wdata_i[NumGpio-1:0];
            ADDR_MOE_LOWER:   oe_d          = masked_update(oe_q, reg_wdata_i, 1'b0);
            ADDR_MOE_UPPER:   oe_d          = masked_update(oe_q, reg_wdata_i, 1'b1);
            ADDR_CTRL_RISE:   rise_d        = reg_wdata_i[NumGpio-1:0];
            ADDR_CTRL_FALL:   fall_d        = reg_wdata_i[NumGpio-1:0];
            ADDR_CTRL_LVLHI:  lvlhi_d       = reg_wdata_i[NumGpio-1:0];
            ADDR_CTRL_LVLLO:  lvllo_d       = reg_wdata_i[NumGpio-1:0];
            ADDR_FILTER_EN:   filt_en_d     = reg_wdata_i[NumGpio-1:0];
            ADDR_FILTER_THR:  thresh_d      = reg_wdata_i[FilterCntWidth-1:0];
            default: ;
         endcase
      end
   end

   // Sticky interrupt state; a live event overrides a same-cycle clear
   always_comb begin
      intr_state_d = (intr_state_q & ~w_w1c) | w_test | w_event;
   end

   // Read mux; samples pre-write values so a simultaneous write is not seen
   always_comb begin
      rdata_d = '0;
      if (reg_re_i) begin
         case (reg_addr_i)
            ADDR_INTR_STATE:  rdata_d = 32'(intr_state_q);
            ADDR_INTR_ENABLE: rdata_d = 32'(intr_enable_q);
            ADDR_DATA_IN:     rdata_d = 32'(w_stable);
            ADDR_DIRECT_OUT:  rdata_d = w_out32;
            ADDR_MOUT_LOWER:  rdata_d = {16'h0, w_out32[15:0]};
            ADDR_MOUT_UPPER:  rdata_d = {16'h0, w_out32[31:16]};
            ADDR_DIRECT_OE:   rdata_d = w_oe32;
            ADDR_MOE_LOWER:   rdata_d = {16'h0, w_oe32[15:0]};
            ADDR_MOE_UPPER:   rdata_d = {16'h0, w_oe32[31:16]};
            ADDR_CTRL_RISE:   rdata_d = 32'(rise_q);
            ADDR_CTRL_FALL:   rdata_d = 32'(fall_q);
            ADDR_CTRL_LVLHI:  rdata_d = 32'(lvlhi_q);
            ADDR_CTRL_LVLLO:  rdata_d = 32'(lvllo_q);
            ADDR_FILTER_EN:   rdata_d = 32'(filt_en_q);
            ADDR_FILTER_THR:  rdata_d = 32'(thresh_q);
            default:          rdata_d = '0;
         endcase
      end
   end

   // Register bank and registered read response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         intr_state_q  <= '0;
         intr_enable_q <= '0;
         out_q         <= '0;
         oe_q          <= '0;
         rise_q        <= '0;
         fall_q        <= '0;
         lvlhi_q       <= '0;
         lvllo_q       <= '0;
         filt_en_q     <= '0;
         thresh_q      <= '0;
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
      end else begin
         intr_state_q  <= intr_state_d;
         intr_enable_q <= intr_enable_d;
         out_q         <= out_d;
         oe_q          <= oe_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         lvlhi_q       <= lvlhi_d;
         lvllo_q       <= lvllo_d;
         filt_en_q     <= filt_en_d;
         thresh_q      <= thresh_d;
         rdata_q       <= rdata_d;
         rvalid_q      <= reg_re_i;
      end
   end

   assign reg_rdata_o   = rdata_q;
   assign reg_rvalid_o  = rvalid_q;
   assign cio_gpio_o    = out_q;
   assign cio_gpio_en_o = oe_q;
   assign intr_o        = intr_state_q & intr_enable_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_bank.sv
// ============================================================================
//  Module   : tb_gpio_bank
//  Purpose  : Self-checking bench for gpio_bank; a 32-pin instance for the
//             main behaviour and an 8-pin instance for narrow-bank boundaries.
//             Read expectations are queued at issue and compared on rvalid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-pin instance
   logic        a_rst, a_we, a_re;
   logic [3:0]  a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic        a_rvalid;
   logic [31:0] a_gin, a_gout, a_gen, a_intr;

   // 8-pin instance
   logic        b_rst, b_we, b_re;
   logic [3:0]  b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic        b_rvalid;
   logic [7:0]  b_gin, b_gout, b_gen, b_intr;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] qa_exp[$];
   string       qa_tag[$];
   logic [31:0] qb_exp[$];
   string       qb_tag[$];
   logic        a_re_last = 1'b0;
   logic        b_re_last = 1'b0;

   gpio_bank #(.NumGpio(32), .SyncStages(2), .FilterCntWidth(4)) u_dut_a (
      .clk_i        (clk),
      .rst_i        (a_rst),
      .reg_we_i     (a_we),
      .reg_re_i     (a_re),
      .reg_addr_i   (a_addr),
      .reg_wdata_i  (a_wdata),
      .reg_rdata_o  (a_rdata),
      .reg_rvalid_o (a_rvalid),
      .cio_gpio_i   (a_gin),
      .cio_gpio_o   (a_gout),
      .cio_gpio_en_o(a_gen),
      .intr_o       (a_intr)
   );

   gpio_bank #(.NumGpio(8), .SyncStages(2), .FilterCntWidth(4)) u_dut_b (
      .clk_i        (clk),
      .rst_i        (b_rst),
      .reg_we_i     (b_we),
      .reg_re_i     (b_re),
      .reg_addr_i   (b_addr),
      .reg_wdata_i  (b_wdata),
      .reg_rdata_o  (b_rdata),
      .reg_rvalid_o (b_rvalid),
      .cio_gpio_i   (b_gin),
      .cio_gpio_o   (b_gout),
      .cio_gpio_en_o(b_gen),
      .intr_o       (b_intr)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit sel_b, input logic [3:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      if (sel_b) begin b_we = 1'b1; b_addr = addr; b_wdata = data; end
      else       begin a_we = 1'b1; a_addr = addr; a_wdata = data; end
      @(posedge clk); #1;
      a_we = 1'b0;
      b_we = 1'b0;
   endtask

   task automatic rd_issue(input bit sel_b, input logic [3:0] addr, input logic [31:0] exp, input string tag);
      if (sel_b) begin b_re = 1'b1; b_addr = addr; qb_exp.push_back(exp); qb_tag.push_back(tag); end
      else       begin a_re = 1'b1; a_addr = addr; qa_exp.push_back(exp); qa_tag.push_back(tag); end
   endtask

   task automatic rd(input bit sel_b, input logic [3:0] addr, input logic [31:0] exp, input string tag);
      @(posedge clk); #1;
      rd_issue(sel_b, addr, exp, tag);
      @(posedge clk); #1;
      a_re = 1'b0;
      b_re = 1'b0;
   endtask

   // Read-response monitor: rvalid must follow re by exactly one cycle, and
   // each response is compared with the oldest queued expectation.
   always @(negedge clk) begin
      if (a_rvalid || a_re_last)
         check_value("a_rvalid_timing", 32'(a_rvalid), 32'(a_re_last));
      if (a_rvalid) begin
         check_value("a_sb_has_entry", 32'(qa_exp.size() != 0), 32'd1);
         if (qa_exp.size() != 0) check_value(qa_tag.pop_front(), a_rdata, qa_exp.pop_front());
      end
      a_re_last = a_re;
      if (b_rvalid || b_re_last)
         check_value("b_rvalid_timing", 32'(b_rvalid), 32'(b_re_last));
      if (b_rvalid) begin
         check_value("b_sb_has_entry", 32'(qb_exp.size() != 0), 32'd1);
         if (qb_exp.size() != 0) check_value(qb_tag.pop_front(), b_rdata, qb_exp.pop_front());
      end
      b_re_last = b_re;
   end

   initial begin
      a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_addr = '0; a_wdata = '0; a_gin = '0;
      b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_addr = '0; b_wdata = '0; b_gin = '0;
      idle(3);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Reset state
      check_value("rst_gpio_o", a_gout, 32'h0);
      check_value("rst_gpio_en", a_gen, 32'h0);
      check_value("rst_intr", a_intr, 32'h0);
      check_value("rst_rdata", a_rdata, 32'h0);
      check_value("rst_rvalid", 32'(a_rvalid), 32'h0);
      for (int k = 0; k < 16; k++) rd(1'b0, 4'(k), 32'h0, $sformatf("rst_rd%0d", k));

      // Direct and masked output
      wr(1'b0, 4'd4, 32'hA5A5_0F0F);
      wr(1'b0, 4'd5, 32'h00FF_1234);
      check_value("mout_lo_pads", a_gout, 32'hA5A5_0F34);
      rd(1'b0, 4'd5, 32'h0000_0F34, "mout_lo_rd");
      rd(1'b0, 4'd4, 32'hA5A5_0F34, "dout_rd");
      rd(1'b0, 4'd6, 32'h0000_A5A5, "mout_up_rd");
      wr(1'b0, 4'd6, 32'hF000_5A5A);
      check_value("mout_up_pads", a_gout, 32'h55A5_0F34);

      // Direct and masked output enable
      wr(1'b0, 4'd7, 32'hA5A5_0F0F);
      wr(1'b0, 4'd8, 32'h00FF_1234);
      check_value("moe_lo_pads", a_gen, 32'hA5A5_0F34);
      rd(1'b0, 4'd8, 32'h0000_0F34, "moe_lo_rd");
      wr(1'b0, 4'd9, 32'hF000_5A5A);
      check_value("moe_up_pads", a_gen, 32'h55A5_0F34);
      rd(1'b0, 4'd9, 32'h0000_55A5, "moe_up_rd");

      // Simultaneous write and read returns the old value
      @(posedge clk); #1;
      a_we = 1'b1; a_wdata = 32'h0;
      rd_issue(1'b0, 4'd4, 32'h55A5_0F34, "rw_same_cycle");
      @(posedge clk); #1;
      a_we = 1'b0; a_re = 1'b0;
      check_value("rw_same_pads", a_gout, 32'h0);

      // Debounce filter on pin 3, threshold 5
      wr(1'b0, 4'd14, 32'h0000_0008);
      wr(1'b0, 4'd15, 32'h0000_0005);
      rd(1'b0, 4'd15, 32'h0000_0005, "thresh_rd");
      @(posedge clk); #1;
      a_gin[3] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      a_gin[3] = 1'b0;
      idle(10);
      rd(1'b0, 4'd3, 32'h0, "filt_pulse_rejected");
      @(posedge clk); #1;
      a_gin[3] = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      rd_issue(1'b0, 4'd3, 32'h0, "filt_edge7");
      @(posedge clk); #1;
      rd_issue(1'b0, 4'd3, 32'h8, "filt_edge8");
      @(posedge clk); #1;
      a_re = 1'b0;

      // Rising-edge interrupt on pin 0
      wr(1'b0, 4'd10, 32'h1);
      wr(1'b0, 4'd1, 32'h1);
      @(posedge clk); #1;
      a_gin[0] = 1'b1;
      idle(5);
      check_value("rise_intr", a_intr, 32'h1);
      rd(1'b0, 4'd0, 32'h1, "rise_state");
      @(posedge clk); #1;
      a_gin[0] = 1'b0;
      idle(5);
      @(posedge clk); #1;
      a_gin[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      a_we = 1'b1; a_addr = 4'd0; a_wdata = 32'h1;
      @(posedge clk); #1;
      a_we = 1'b0;
      check_value("w1c_vs_event_intr", a_intr, 32'h1);
      rd(1'b0, 4'd0, 32'h1, "w1c_vs_event_state");
      wr(1'b0, 4'd0, 32'h1);
      check_value("w1c_clear_intr", a_intr, 32'h0);
      rd(1'b0, 4'd0, 32'h0, "w1c_clear_state");

      // Level-low interrupt on pin 7 and INTR_TEST
      wr(1'b0, 4'd1, 32'h0);
      wr(1'b0, 4'd13, 32'h80);
      idle(2);
      check_value("lvllo_masked_intr", a_intr, 32'h0);
      rd(1'b0, 4'd0, 32'h80, "lvllo_state");
      wr(1'b0, 4'd1, 32'h80);
      check_value("lvllo_enabled_intr", a_intr, 32'h80);
      wr(1'b0, 4'd2, 32'h8000_0000);
      rd(1'b0, 4'd0, 32'h8000_0080, "intr_test_state");
      rd(1'b0, 4'd2, 32'h0, "intr_test_rd");
      wr(1'b0, 4'd0, 32'h80);
      rd(1'b0, 4'd0, 32'h8000_0080, "lvl_reasserts");
      rd(1'b0, 4'd3, 32'h9, "data_in_pins");

      // Narrow bank: bits above NumGpio read as zero, upper masks ignored
      wr(1'b1, 4'd7, 32'hFFFF_FFFF);
      check_value("b_oe_pads", 32'(b_gen), 32'hFF);
      rd(1'b1, 4'd7, 32'h0000_00FF, "b_oe_rd");
      wr(1'b1, 4'd6, 32'hFFFF_FFFF);
      rd(1'b1, 4'd4, 32'h0, "b_upper_ignored");
      wr(1'b1, 4'd5, 32'hFFFF_FFFF);
      check_value("b_mout_lo_pads", 32'(b_gout), 32'hFF);
      wr(1'b1, 4'd14, 32'h1);
      wr(1'b1, 4'd15, 32'hFFFF_FFFF);
      rd(1'b1, 4'd15, 32'hF, "b_thresh_rd");

      // Reset in the middle of a filter count
      @(posedge clk); #1;
      b_gin[0] = 1'b1;
      idle(8);
      b_rst = 1'b1;
      b_gin = '0;
      idle(2);
      b_rst = 1'b0;
      check_value("b_rst_gout", 32'(b_gout), 32'h0);
      check_value("b_rst_gen", 32'(b_gen), 32'h0);
      rd(1'b1, 4'd3, 32'h0, "b_rst_data_in");
      rd(1'b1, 4'd14, 32'h0, "b_rst_filt_en");
      rd(1'b1, 4'd15, 32'h0, "b_rst_thresh");

      idle(4);
      check_value("a_sb_drained", 32'(qa_exp.size()), 32'd0);
      check_value("b_sb_drained", 32'(qb_exp.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised next-generation GPIO bank.
- Drives NumGpio pads with direct and masked output/output-enable writes.
- Samples pad inputs through per-pin synchroniser and programmable-threshold debounce filter; raises sticky edge/level interrupts.
- Sits behind a simple single-clock register port. The bus adapter lives outside this block.

Parameters:
- NumGpio, 32, number of pins; legal range 1..32; register bits at or above NumGpio are read-only zero.
- SyncStages, 2, input synchroniser depth; legal range 0..3; 0 means inputs are already synchronous.
- FilterCntWidth, 4, debounce counter width; sets the maximum threshold to 2^FilterCntWidth-1.

Ports:
- clk_i, input, 1, sole clock.
- rst_i, input, 1, reset. One clock; reset is synchronous and active-high.
- reg_we_i, input, 1, write strobe.
- reg_re_i, input, 1, read strobe.
- reg_addr_i, input, 4, word address.
- reg_wdata_i, input, 32, write data.
- reg_rdata_o, output, 32, read data, valid with reg_rvalid_o.
- reg_rvalid_o, output, 1, one-cycle read-data valid pulse.
- cio_gpio_i, input, NumGpio, pad inputs.
- cio_gpio_o, output, NumGpio, pad output data.
- cio_gpio_en_o, output, NumGpio, pad output enables.
- intr_o, output, NumGpio, per-pin interrupt = intr_state & intr_enable.

Behaviour:
- Reset (rst_i high at a clk_i edge) clears every register, synchroniser stage, filter counter, stable value and edge history to 0.
- Reset values: cio_gpio_o=0, cio_gpio_en_o=0, intr_o=0, reg_rdata_o=0, reg_rvalid_o=0.
- Reset mid-filter discards the count.
- Register map (word address):
  - 0 INTR_STATE: RW1C.
  - 1 INTR_ENABLE: RW.
  - 2 INTR_TEST: WO; a write sets the written 1-bits in INTR_STATE; reads as 0.
  - 3 DATA_IN: RO, filtered inputs.
  - 4 DIRECT_OUT: RW.
  - 5 MASKED_OUT_LOWER, 6 MASKED_OUT_UPPER.
  - 7 DIRECT_OE: RW.
  - 8 MASKED_OE_LOWER, 9 MASKED_OE_UPPER.
  - 10 CTRL_RISE, 11 CTRL_FALL, 12 CTRL_LVLHI, 13 CTRL_LVLLO.
  - 14 FILTER_EN: RW.
  - 15 FILTER_THRESH: RW, low FilterCntWidth bits.
- Masked writes: wdata[31:16]=mask, wdata[15:0]=data.
  - Lower register applies to pins 15:0; upper applies to pins 31:16.
  - out[i] = mask ? data : out[i].
  - Mask bits for pins >= NumGpio are ignored.
- Masked reads return {16'h0, current 16-bit slice}.
- All writes take effect on the clock edge after reg_we_i. Pads see the new value in that cycle (latency 1).
- Reads: reg_rdata_o and reg_rvalid_o are registered and valid exactly 1 cycle after reg_re_i.
  - Reading address 2 returns 0.
  - reg_we_i and reg_re_i together: the read returns the pre-write value.
- Input path: SyncStages flops, then the filter.
- Filter per pin, when FILTER_EN[i]=1:
  - Keeps a stable value and a counter.
  - If the synced input equals the stable value, the counter clears.
  - Otherwise the counter increments. When counter == FILTER_THRESH, the stable value takes the input and the counter clears.
  - A change must therefore persist THRESH+1 consecutive cycles.
  - THRESH=0 gives pass-through plus 1 cycle.
  - Counter saturates and never wraps.
- Filter per pin, when FILTER_EN[i]=0: the stable value follows the synced input every cycle and the counter is held at 0. Toggling enable never produces a glitch.
- DATA_IN = stable value.
- Events per pin, computed from stable value s and its 1-cycle delayed copy p:
  - rise = ~p & s & RISE
  - fall = p & ~s & FALL
  - lvlhi = s & LVLHI
  - lvllo = ~s & LVLLO
- Any event sets INTR_STATE[i], independent of INTR_ENABLE.
- Same-cycle W1C and event on the same bit: the event wins (bit stays 1).
- A level event re-sets the bit every cycle while active.
- intr_o is combinational from the flops; no extra latency beyond the state update.

Test Plan:
- Reset, then read addresses 0..15 -> every read returns 0 with reg_rvalid_o one cycle after reg_re_i; cio_gpio_o=0, cio_gpio_en_o=0.
- Write DIRECT_OUT=32'hA5A5_0F0F, then MASKED_OUT_LOWER=32'h00FF_1234 -> cio_gpio_o=32'hA5A5_0F34; MASKED_OUT_LOWER reads 32'h0000_0F34. Repeat on the OE registers.
- FILTER_EN[3]=1, THRESH=5, SyncStages=2; pulse pin 3 high for 5 cycles, then hold high for 6 cycles -> DATA_IN[3] stays 0 during the pulse and rises 2+6 cycles after the steady high begins.
- CTRL_RISE[0]=1, INTR_ENABLE[0]=1; drive pin 0 low->high -> INTR_STATE=1 and intr_o[0]=1; W1C in the same cycle as a second rise event leaves the bit 1; W1C with no event clears it.
- CTRL_LVLLO[7]=1, INTR_ENABLE=0; pin 7 low -> INTR_STATE[7]=1 and intr_o[7]=0; set INTR_ENABLE[7] -> intr_o[7]=1; write INTR_TEST=32'h8000_0000 with NumGpio=32 -> bit 31 set.
- NumGpio=8; write DIRECT_OE=32'hFFFF_FFFF -> reads back 32'h0000_00FF; assert rst_i mid-filter-count -> all state clears, DATA_IN=0.
